divide: RTL and testbench

//  Sequential restoring (shift-subtract) unsigned divider; the inverse of the

---
 rtl/divide_pkg.sv | 8 +
 rtl/divide_if.sv | 14 +
 rtl/divide_step.sv | 16 +
 rtl/divide.sv | 81 ++++++++
 tb/tb_divide.sv | 126 ++++++++++++
 5 files changed

// File: rtl/divide_pkg.sv
// divide_pkg: shared state encodings, default width and counter sizing for the divider
package divide_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
  localparam int N_DEF = 32;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/divide_if.sv
// divide_if: LA/LB/s/Finish handshake and operand/result bus shared with the multiplier
interface divide_if #(parameter int n = 32);
  logic         LA;
  logic         LB;
  logic         s;
  logic [n-1:0] DataA;
  logic [n-1:0] DataB;
  logic [n-1:0] Q;
  logic [n-1:0] R;
  logic         Finish;
  logic         DivZero;
  modport master (output LA, LB, s, DataA, DataB, input Q, R, Finish, DivZero);
  modport slave  (input LA, LB, s, DataA, DataB, output Q, R, Finish, DivZero);
endinterface

// File: rtl/divide_step.sv
// divide_step: one combinational restoring step, shift in a dividend bit and try to subtract
module divide_step #(parameter int n = 32) (
  input  logic [n-1:0] r_i,
  input  logic         q_msb_i,
  input  logic [n-1:0] b_i,
  output logic [n-1:0] r_o,
  output logic         q_bit_o
);
  logic [n:0] t;
  logic [n:0] d;
  // Partial remainder is widened by one bit so R[n-1]=1 cannot overflow the compare
  assign t       = {r_i, q_msb_i};
  assign d       = t - {1'b0, b_i};
  assign q_bit_o = t >= {1'b0, b_i};
  assign r_o     = q_bit_o ? d[n-1:0] : t[n-1:0];
endmodule

// File: rtl/divide.sv
// divide: sequential restoring unsigned divider, one quotient bit per clock
module divide
  import divide_pkg::*;
#(parameter int n = N_DEF) (
  input  logic clk,
  input  logic reset,
  divide_if.slave bus
);
  localparam int CW = cnt_w(n);
  state_e        state_q, state_d;
  logic [n-1:0]  q_q, q_d, r_q, r_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;
  logic [n-1:0]  r_nx;
  logic          q_bit;
  divide_step #(.n(n)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[n-1]),
    .b_i     (b_q),
    .r_o     (r_nx),
    .q_bit_o (q_bit)
  );
  // State and datapath registers; reset wins over everything, including a running division
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end
  // Next-state and datapath updates; loads only in IDLE, start tests the registered divisor
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        q_d = bus.LA ? bus.DataA : q_q;
        b_d = bus.LB ? bus.DataB : b_q;
        if (bus.s && b_q != '0) begin
          r_d     = '0;
          cnt_d   = CW'(n - 1);
          state_d = RUN;
        end else if (bus.s) begin
          q_d     = '1;
          r_d     = q_q;
          dz_d    = 1'b1;
          state_d = DONE;
        end
      end
      RUN: begin
        r_d     = r_nx;
        q_d     = {q_q[n-2:0], q_bit};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? DONE : RUN;
      end
      DONE: begin
        state_d = bus.s ? DONE : IDLE;
        dz_d    = bus.s ? dz_q : 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.Q       = q_q;
  assign bus.R       = r_q;
  assign bus.Finish  = state_q == DONE;
  assign bus.DivZero = dz_q;
endmodule

// File: tb/tb_divide.sv
// tb_divide: directed and random divisions checked against plain integer division
module tb_divide;
  localparam int N = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  divide_if #(.n(N)) bus ();
  divide #(.n(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == 0) ? {N{1'b1}} : a / b;
  endfunction
  function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction
  task automatic do_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int hold, input bit poke);
    logic [N-1:0] eq, er;
    int lat;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    bus.DataA = a;
    bus.DataB = b;
    bus.LA = 1'b1;
    bus.LB = 1'b1;
    tick();
    bus.LA = 1'b0;
    bus.LB = 1'b0;
    bus.s = 1'b1;
    lat = 0;
    while (!bus.Finish && lat < 100) begin
      bus.LA = poke && lat == 3;
      bus.LB = poke && lat == 3;
      bus.DataA = poke ? 32'h1234_5678 : a;
      bus.DataB = poke ? 32'h0000_0003 : b;
      tick();
      lat++;
    end
    bus.LA = 1'b0;
    bus.LB = 1'b0;
    chk({tag, " latency"}, N'(lat), (b == 0) ? N'(1) : N'(N + 1));
    chk({tag, " Q"}, bus.Q, eq);
    chk({tag, " R"}, bus.R, er);
    chk({tag, " DivZero"}, N'(bus.DivZero), N'(b == 0));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " hold Finish"}, N'(bus.Finish), N'(1));
      chk({tag, " hold Q"}, bus.Q, eq);
      chk({tag, " hold R"}, bus.R, er);
    end
    bus.s = 1'b0;
    tick();
    chk({tag, " idle Finish"}, N'(bus.Finish), N'(0));
    chk({tag, " idle DivZero"}, N'(bus.DivZero), N'(0));
    chk({tag, " idle Q kept"}, bus.Q, eq);
    chk({tag, " idle R kept"}, bus.R, er);
  endtask
  initial begin
    logic [N-1:0] ra, rb;
    bus.LA = 1'b0;
    bus.LB = 1'b0;
    bus.s = 1'b0;
    bus.DataA = '0;
    bus.DataB = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset Q", bus.Q, '0);
    chk("reset R", bus.R, '0);
    chk("reset Finish", N'(bus.Finish), N'(0));
    chk("reset DivZero", N'(bus.DivZero), N'(0));
    do_div("100/7", 32'd100, 32'd7, 0, 1'b0);
    do_div("max/1", 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_div("3/10", 32'd3, 32'd10, 0, 1'b0);
    do_div("0/5", 32'd0, 32'd5, 0, 1'b0);
    do_div("5/0", 32'd5, 32'd0, 2, 1'b0);
    bus.DataA = 32'd100;
    bus.DataB = 32'd7;
    bus.LA = 1'b1;
    bus.LB = 1'b1;
    tick();
    bus.LA = 1'b0;
    bus.LB = 1'b0;
    bus.s = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    bus.s = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrun reset Q", bus.Q, '0);
    chk("midrun reset R", bus.R, '0);
    chk("midrun reset Finish", N'(bus.Finish), N'(0));
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("midrun no Finish", N'(bus.Finish), N'(0));
    end
    do_div("100/7 after reset", 32'd100, 32'd7, 0, 1'b0);
    do_div("hold+poke", 32'd100, 32'd7, 5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = (i == 7) ? 32'd0 : ($urandom | 32'h8000_0000);
      endcase
      do_div("random", ra, rb, i % 3, i[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
